// File: rtl/systolic_pkg.sv
// Shared types and default dimensions for the systolic array front end.
package systolic_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_N            = 8;
  localparam int DEF_FIFO_DEPTH   = 16;
  localparam int DEF_DRAIN_CYCLES = 2 * DEF_N - 1;

  typedef logic signed [DEF_DATA_WIDTH-1:0] data_t;
  typedef data_t row_t [DEF_N];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/row_fifo.sv
// Synchronous row buffer; the head entry is readable in the same cycle it is popped.
module row_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/a_skew_feeder.sv
// Buffers A rows and feeds them to the systolic array with per-lane triangular skew,
// then flushes the array with zero rows and reports tile completion.
module a_skew_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int N            = DEF_N,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [DATA_WIDTH-1:0]        in_row [N],
  input  logic                                in_last,
  output logic signed [DATA_WIDTH-1:0]        a_out [N],
  output logic                                enable_out,
  output logic                                tile_done,
  output feeder_state_e                       dbg_state,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     dbg_fifo_count
);

  localparam int FW    = N * DATA_WIDTH + 1;
  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  // Handshake: a row transfers on a rising clk edge where in_valid && in_ready;
  // in_ready depends only on the registered fill level and is low during rst.
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0] fifo_wr_data, fifo_rd_data;
  logic          popped_last;

  feeder_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             advance;
  logic             drain_fin;
  logic             drain_fin_q;
  logic             enable_q;
  logic             tile_done_q;
  logic signed [DATA_WIDTH-1:0] stage_in [N];

  assign in_ready  = !rst && !fifo_full;
  assign fifo_push = in_valid && in_ready;

  always_comb begin
    fifo_wr_data    = '0;
    fifo_wr_data[0] = in_last;
    for (int i = 0; i < N; i++) fifo_wr_data[1 + i*DATA_WIDTH +: DATA_WIDTH] = in_row[i];
  end

  row_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (fifo_wr_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (dbg_fifo_count)
  );

  assign popped_last = fifo_rd_data[0];

  // The cycle right after the final drain advance is held off so tile_done
  // always precedes the next tile's first enable.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fifo_pop  = 1'b0;
    advance   = 1'b0;
    drain_fin = 1'b0;
    case (state_q)
      IDLE, STREAM: begin
        if (!fifo_empty && !drain_fin_q) begin
          fifo_pop = 1'b1;
          advance  = 1'b1;
          if (popped_last) begin
            state_d = DRAIN;
            cnt_d   = CNT_W'(DRAIN_CYCLES);
          end else begin
            state_d = STREAM;
          end
        end
      end
      DRAIN: begin
        advance = 1'b1;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d   = IDLE;
          drain_fin = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      stage_in[i] = '0;
      if (state_q != DRAIN) stage_in[i] = fifo_rd_data[1 + i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      drain_fin_q <= 1'b0;
      enable_q    <= 1'b0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drain_fin_q <= drain_fin;
      enable_q    <= advance;
      tile_done_q <= drain_fin_q;
    end
  end

  assign enable_out = enable_q;
  assign tile_done  = tile_done_q;
  assign dbg_state  = state_q;

  // Lane i is an (i+1)-deep shift chain that moves only on an advance.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] chain_q [i+1];
    logic signed [DATA_WIDTH-1:0] chain_d [i+1];

    always_comb begin
      for (int j = 0; j <= i; j++) chain_d[j] = chain_q[j];
      if (advance) begin
        chain_d[0] = stage_in[i];
        for (int j = 1; j <= i; j++) chain_d[j] = chain_q[j-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j <= i; j++) chain_q[j] <= '0;
      end else begin
        for (int j = 0; j <= i; j++) chain_q[j] <= chain_d[j];
      end
    end

    assign a_out[i] = chain_q[i];
  end

endmodule
